// File: rtl/wave_seq_ctrl_pkg.sv
// wave_seq_ctrl_pkg
// Shared types for the DDS wave sequencer:
//   wave_t  - generator lane select (SINE, SAW, TRI, SQR)
//   mode_t  - run mode (CONT, BURST, SWEEP)
//   state_t - sequencer FSM states (IDLE, RUN, DONE)
//   decode_mode() maps the raw 2-bit mode field, folding reserved code 3 onto CONT.
package wave_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    SINE = 2'd0,
    SAW  = 2'd1,
    TRI  = 2'd2,
    SQR  = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    CONT  = 2'd0,
    BURST = 2'd1,
    SWEEP = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return BURST;
      2'd2:    return SWEEP;
      default: return CONT;
    endcase
  endfunction

endpackage

// File: rtl/wave_seq_ctrl_if.sv
// wave_seq_ctrl_if
// Configuration valid/ready bus for wave_seq_ctrl.
//   cfg_valid   master->slave  config offered
//   cfg_ready   slave->master  config accepted on cfg_valid & cfg_ready
//   cfg_mode    2 bits         0=CONT 1=BURST 2=SWEEP 3=CONT
//   cfg_wave    2 bits         0=SINE 1=SAW 2=TRI 3=SQR
//   cfg_ftw     ACC_W          start tuning word
//   cfg_ftw_end ACC_W          sweep end tuning word
//   cfg_step    ACC_W          sweep increment per phase wrap
//   cfg_cycles  CNT_W          burst length in wraps (0 acts as 1)
interface wave_seq_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [1:0]       cfg_wave;
  logic [ACC_W-1:0] cfg_ftw;
  logic [ACC_W-1:0] cfg_ftw_end;
  logic [ACC_W-1:0] cfg_step;
  logic [CNT_W-1:0] cfg_cycles;

  modport master (
    output cfg_valid, cfg_mode, cfg_wave, cfg_ftw, cfg_ftw_end, cfg_step, cfg_cycles,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_wave, cfg_ftw, cfg_ftw_end, cfg_step, cfg_cycles,
    output cfg_ready
  );
endinterface

// File: rtl/wave_seq_ctrl_phase_acc.sv
// wave_seq_ctrl_phase_acc
// Phase accumulator with carry-out wrap flag.
//   clk, rst  clock, synchronous active-high reset
//   clr       clear accumulator to zero (wins over en)
//   en        advance: acc <= acc + inc (ACC_W-bit wrap-around)
//   inc       tuning word
//   phase     top PH_W bits of the accumulator (register output)
//   wrap      combinational carry of the advance happening this cycle
module wave_seq_ctrl_phase_acc
  import wave_seq_ctrl_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int PH_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic [PH_W-1:0]  phase,
  output logic             wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, inc};
    wrap  = en & ~clr & sum[ACC_W];
    phase = acc[ACC_W-1 -: PH_W];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl
// DDS sequencer: owns the phase accumulator, drives the shared phase bus to
// the LUT generators and registers the selected generator lane for the DAC.
// Modes: continuous tone, N-wrap burst, linear tuning-word sweep.
//   clk, rst      clock, synchronous active-high reset
//   tick          sample-rate enable, accumulator advances only on tick in RUN
//   cfg_bus       configuration valid/ready bus (slave side)
//   start, stop   begin run from IDLE / abort run (stop has priority)
//   gen_data      {sqr,tri,saw,sine} generator outputs for the current phase
//   phase         accumulator top bits to generators
//   wave_sel      shadowed waveform select
//   sample_out    registered selected sample, sample_valid strobes its update
//   busy          high while running
//   done          one-cycle pulse on burst/sweep completion (never on stop)
module wave_seq_ctrl
  import wave_seq_ctrl_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int PH_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  wave_seq_ctrl_if.slave      cfg_bus,
  input  logic [4*PH_W-1:0]   gen_data,
  output logic [PH_W-1:0]     phase,
  output logic [1:0]          wave_sel,
  output logic [PH_W-1:0]     sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

  state_t           state;
  mode_t            sh_mode;
  wave_t            sh_wave;
  logic [ACC_W-1:0] sh_ftw;
  logic [ACC_W-1:0] sh_end;
  logic [ACC_W-1:0] sh_step;
  logic [CNT_W-1:0] sh_cycles;
  logic [ACC_W-1:0] ftw_cur;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             adv_d;

  logic             hs;
  logic             go;
  logic             adv;
  logic             acc_clr;
  logic             wrap;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   burst_len;
  logic             burst_last;
  logic [ACC_W:0]   sweep_sum;
  logic [ACC_W-1:0] sweep_next;
  logic             sweep_last;
  logic [PH_W-1:0]  lane;

  always_comb begin
    hs      = cfg_bus.cfg_valid & ready_q;
    go      = (state == IDLE) & start & ~stop;
    adv     = (state == RUN) & tick & ~stop;
    // Accumulator is held through DONE so the final sample sees the post-wrap
    // phase, and is zeroed on the way back to IDLE.
    acc_clr = go | ((state == RUN) & stop) | (state == DONE);

    cnt_inc    = {1'b0, cnt} + CNT_ONE;
    burst_len  = (sh_cycles == '0) ? CNT_ONE : {1'b0, sh_cycles};
    burst_last = (cnt_inc == burst_len);

    // One extra bit so an overflowing step clamps to the end word.
    sweep_sum  = {1'b0, ftw_cur} + {1'b0, sh_step};
    sweep_next = (sweep_sum > {1'b0, sh_end}) ? sh_end : sweep_sum[ACC_W-1:0];
    sweep_last = (ftw_cur == sh_end);

    case (sh_wave)
      SINE:    lane = gen_data[PH_W-1:0];
      SAW:     lane = gen_data[2*PH_W-1:PH_W];
      TRI:     lane = gen_data[3*PH_W-1:2*PH_W];
      default: lane = gen_data[4*PH_W-1:3*PH_W];
    endcase
  end

  wave_seq_ctrl_phase_acc #(
    .ACC_W (ACC_W),
    .PH_W  (PH_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (adv),
    .inc   (ftw_cur),
    .phase (phase),
    .wrap  (wrap)
  );

  assign cfg_bus.cfg_ready = ready_q;
  assign wave_sel          = sh_wave;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sh_mode      <= CONT;
      sh_wave      <= SINE;
      sh_ftw       <= '0;
      sh_end       <= '0;
      sh_step      <= '0;
      sh_cycles    <= '0;
      ftw_cur      <= '0;
      cnt          <= '0;
      ready_q      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      adv_d        <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else begin
      // Generators see the new phase one cycle after the advancing tick.
      adv_d        <= adv;
      sample_valid <= adv_d;
      if (adv_d) begin
        sample_out <= lane;
      end

      case (state)
        IDLE: begin
          if (hs) begin
            sh_mode   <= decode_mode(cfg_bus.cfg_mode);
            sh_wave   <= wave_t'(cfg_bus.cfg_wave);
            sh_ftw    <= cfg_bus.cfg_ftw;
            sh_end    <= cfg_bus.cfg_ftw_end;
            sh_step   <= cfg_bus.cfg_step;
            sh_cycles <= cfg_bus.cfg_cycles;
          end
          if (go) begin
            state   <= RUN;
            busy    <= 1'b1;
            ready_q <= 1'b0;
            ftw_cur <= hs ? cfg_bus.cfg_ftw : sh_ftw;
            cnt     <= '0;
          end
        end

        RUN: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end else if (wrap) begin
            case (sh_mode)
              BURST: begin
                if (burst_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  cnt <= cnt_inc[CNT_W-1:0];
                end
              end
              SWEEP: begin
                if (sweep_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  ftw_cur <= sweep_next;
                end
              end
              default: ;
            endcase
          end
        end

        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl
// Self-checking bench for wave_seq_ctrl: directed scenarios plus a randomized
// run, all compared against a run-level reference model of the sequencer.
module tb_wave_seq_ctrl;
  localparam int ACC_W = 24;
  localparam int PH_W  = 8;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst, tick, start, stop;
  logic [31:0] gen_data;
  logic [7:0]  phase, sample_out;
  logic [1:0]  wave_sel;
  logic        sample_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  wave_seq_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) cfg_bus ();

  wave_seq_ctrl #(.ACC_W(ACC_W), .PH_W(PH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .cfg_bus(cfg_bus), .gen_data(gen_data), .phase(phase), .wave_sel(wave_sel),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stand-in generators: distinct combinational functions of phase per lane.
  function automatic logic [7:0] gen_lane(input logic [1:0] w, input logic [7:0] p);
    case (w)
      2'd0:    return p + 8'h40;
      2'd1:    return p;
      2'd2:    return p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default: return p[7] ? 8'hFF : 8'h00;
    endcase
  endfunction

  assign gen_data = {gen_lane(2'd3, phase), gen_lane(2'd2, phase),
                     gen_lane(2'd1, phase), gen_lane(2'd0, phase)};

  // Reference model: one "run" with wrap counting, tuning-word schedule and a
  // pending-sample flag, advanced once per clock edge.
  bit          m_run, m_fin, m_pend;
  logic [23:0] m_acc, m_ftw;
  int          m_wraps, sh_mode, sh_cycles;
  logic [1:0]  sh_wave;
  logic [23:0] sh_ftw, sh_end, sh_step;
  logic [7:0]  e_sout;
  bit          e_svalid;

  task automatic model_edge();
    bit adv;
    logic [24:0] s;
    longint t;
    adv = m_run && tick && !stop;
    if (m_pend) e_sout = gen_lane(sh_wave, m_acc[23:16]);
    e_svalid = m_pend;
    m_pend = adv;
    if (rst) begin
      m_run = 0; m_fin = 0; m_pend = 0; m_acc = '0; m_ftw = '0; m_wraps = 0;
      sh_mode = 0; sh_wave = '0; sh_ftw = '0; sh_end = '0; sh_step = '0;
      sh_cycles = 0; e_sout = '0; e_svalid = 0;
    end else if (m_fin) begin
      m_fin = 0;
      m_acc = '0;
    end else if (m_run) begin
      if (stop) begin
        m_run = 0;
        m_acc = '0;
      end else if (tick) begin
        s = {1'b0, m_acc} + {1'b0, m_ftw};
        m_acc = s[23:0];
        if (s[24]) begin
          m_wraps++;
          if (sh_mode == 1 && m_wraps >= ((sh_cycles == 0) ? 1 : sh_cycles)) begin
            m_run = 0; m_fin = 1;
          end else if (sh_mode == 2) begin
            if (m_ftw == sh_end) begin
              m_run = 0; m_fin = 1;
            end else begin
              t = longint'(m_ftw) + longint'(sh_step);
              m_ftw = (t > longint'(sh_end)) ? sh_end : 24'(t);
            end
          end
        end
      end
    end else begin
      if (cfg_bus.cfg_valid) begin
        sh_mode   = (cfg_bus.cfg_mode == 2'd3) ? 0 : int'(cfg_bus.cfg_mode);
        sh_wave   = cfg_bus.cfg_wave;
        sh_ftw    = cfg_bus.cfg_ftw;
        sh_end    = cfg_bus.cfg_ftw_end;
        sh_step   = cfg_bus.cfg_step;
        sh_cycles = int'(cfg_bus.cfg_cycles);
      end
      if (start && !stop) begin
        m_run = 1; m_acc = '0; m_ftw = sh_ftw; m_wraps = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_cfg(input int mode, input int wave, input logic [23:0] ftw,
                         input logic [23:0] fend, input logic [23:0] step, input int cycles);
    cfg_bus.cfg_mode    = 2'(mode);
    cfg_bus.cfg_wave    = 2'(wave);
    cfg_bus.cfg_ftw     = ftw;
    cfg_bus.cfg_ftw_end = fend;
    cfg_bus.cfg_step    = step;
    cfg_bus.cfg_cycles  = 16'(cycles);
  endtask

  task automatic test_reset();
    rst = 1; tick = 1; start = 0; stop = 0; cfg_bus.cfg_valid = 0;
    set_cfg(0, 0, 24'h0, 24'h0, 24'h0, 0);
    cyc(); cyc();
    rst = 0;
    vectors++; if (phase !== 8'h00) begin miscompares++; $display("FAIL reset_phase: got %h want 00", phase); end
    vectors++; if (sample_out !== 8'h00) begin miscompares++; $display("FAIL reset_sample: got %h want 00", sample_out); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_svalid: got %b want 0", sample_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cfg_bus.cfg_ready); end
    vectors++; if (wave_sel !== 2'd0) begin miscompares++; $display("FAIL reset_wave: got %0d want 0", wave_sel); end
  endtask

  task automatic test_cont();
    logic [7:0] want;
    set_cfg(0, 1, 24'h100000, 24'h0, 24'h0, 0);
    cfg_bus.cfg_valid = 1; start = 1; tick = 1;
    cyc();
    cfg_bus.cfg_valid = 0; start = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      want = 8'((k * 16) % 256);
      vectors++; if (phase !== want) begin miscompares++; $display("FAIL cont_phase[%0d]: got %h want %h", k, phase, want); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cont_busy[%0d]: got %b want 1", k, busy); end
      if (k >= 2) begin
        want = 8'(((k - 1) * 16) % 256);
        vectors++; if (sample_valid !== 1'b1) begin miscompares++; $display("FAIL cont_svalid[%0d]: got %b want 1", k, sample_valid); end
        vectors++; if (sample_out !== want) begin miscompares++; $display("FAIL cont_sample[%0d]: got %h want %h", k, sample_out, want); end
      end else begin
        vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL cont_svalid_first: got %b want 0", sample_valid); end
      end
    end
    stop = 1; cyc(); stop = 0;
    vectors++; if (busy !== 1'b0 || phase !== 8'h00) begin miscompares++; $display("FAIL cont_stop: got busy=%b phase=%h want busy=0 phase=00", busy, phase); end
    cyc();
  endtask

  task automatic test_burst(input int cycles, input int exp_busy);
    int n;
    set_cfg(1, 2, 24'h100000, 24'h0, 24'h0, cycles);
    cfg_bus.cfg_valid = 1; start = 1; tick = 1;
    cyc();
    cfg_bus.cfg_valid = 0; start = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; cyc(); end
    vectors++; if (n !== exp_busy) begin miscompares++; $display("FAIL burst%0d_busy_len: got %0d want %0d", cycles, n, exp_busy); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL burst%0d_done: got %b want 1", cycles, done); end
    cyc();
    vectors++; if (done !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL burst%0d_after: got done=%b ready=%b want 0/1", cycles, done, cfg_bus.cfg_ready); end
    vectors++; if (sample_valid !== e_svalid || sample_out !== e_sout) begin miscompares++; $display("FAIL burst%0d_final_sample: got %b/%h want %b/%h", cycles, sample_valid, sample_out, e_svalid, e_sout); end
    cyc();
  endtask

  task automatic test_sweep(input logic [23:0] fend, input int exp_busy);
    int n;
    set_cfg(2, 0, 24'h100000, fend, 24'h100000, 0);
    cfg_bus.cfg_valid = 1; start = 1; tick = 1;
    cyc();
    cfg_bus.cfg_valid = 0; start = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++; cyc();
      vectors++; if (phase !== m_acc[23:16]) begin miscompares++; $display("FAIL sweep_phase[%0d]: got %h want %h", n, phase, m_acc[23:16]); end
    end
    vectors++; if (n !== exp_busy) begin miscompares++; $display("FAIL sweep_%h_busy_len: got %0d want %0d", fend, n, exp_busy); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sweep_%h_done: got %b want 1", fend, done); end
    cyc(); cyc();
  endtask

  task automatic test_stop();
    set_cfg(0, 0, 24'h100000, 24'h0, 24'h0, 0);
    cfg_bus.cfg_valid = 1; start = 1; tick = 1;
    cyc();
    cfg_bus.cfg_valid = 0; start = 0;
    repeat (4) cyc();
    set_cfg(1, 3, 24'h200000, 24'h0, 24'h0, 1);
    stop = 1; start = 1; cfg_bus.cfg_valid = 1;
    cyc();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL stop_done: got %b want 0", done); end
    vectors++; if (phase !== 8'h00) begin miscompares++; $display("FAIL stop_phase: got %h want 00", phase); end
    vectors++; if (cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL stop_ready: got %b want 1", cfg_bus.cfg_ready); end
    vectors++; if (wave_sel !== 2'd0) begin miscompares++; $display("FAIL stop_wave_kept: got %0d want 0", wave_sel); end
    stop = 0; start = 0; cfg_bus.cfg_valid = 0;
    cyc();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL stop_idle: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_tick_gate();
    bit prev;
    set_cfg(0, 2, 24'h123456, 24'h0, 24'h0, 0);
    cfg_bus.cfg_valid = 1; start = 1; tick = 0;
    cyc();
    cfg_bus.cfg_valid = 0; start = 0;
    prev = 0;
    for (int i = 0; i < 48; i++) begin
      tick = (i % 4 == 0);
      cyc();
      vectors++; if (sample_valid !== prev) begin miscompares++; $display("FAIL gate_svalid[%0d]: got %b want %b", i, sample_valid, prev); end
      vectors++; if (phase !== m_acc[23:16]) begin miscompares++; $display("FAIL gate_phase[%0d]: got %h want %h", i, phase, m_acc[23:16]); end
      vectors++; if (sample_out !== e_sout) begin miscompares++; $display("FAIL gate_sample[%0d]: got %h want %h", i, sample_out, e_sout); end
      prev = tick;
    end
    tick = 1; stop = 1; cyc(); stop = 0; cyc();
  endtask

  task automatic test_rst_mid();
    set_cfg(2, 1, 24'h100000, 24'h300000, 24'h100000, 0);
    cfg_bus.cfg_valid = 1; start = 1; tick = 1;
    cyc();
    cfg_bus.cfg_valid = 0; start = 0;
    repeat (10) cyc();
    set_cfg(0, 3, 24'h010000, 24'h0, 24'h0, 0);
    cfg_bus.cfg_valid = 1;
    vectors++; if (cfg_bus.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_ready_run: got %b want 0", cfg_bus.cfg_ready); end
    cyc();
    vectors++; if (wave_sel !== 2'd1) begin miscompares++; $display("FAIL rmid_cfg_ignored: got %0d want 1", wave_sel); end
    cfg_bus.cfg_valid = 0;
    rst = 1; cyc(); rst = 0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || phase !== 8'h00) begin miscompares++; $display("FAIL rmid_state: got busy=%b done=%b phase=%h want 0/0/00", busy, done, phase); end
    vectors++; if (sample_out !== 8'h00 || sample_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_sample: got %h/%b want 00/0", sample_out, sample_valid); end
    vectors++; if (wave_sel !== 2'd0 || cfg_bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_cfg: got wave=%0d ready=%b want 0/1", wave_sel, cfg_bus.cfg_ready); end
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      tick  = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 63) == 0);
      cfg_bus.cfg_valid = ($urandom_range(0, 3) == 0);
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              24'($urandom_range(24'h040000, 24'h400000)),
              24'($urandom_range(24'h040000, 24'h800000)),
              24'($urandom_range(0, 24'h200000)), int'($urandom_range(0, 3)));
      cyc();
      vectors++; if (phase !== m_acc[23:16]) begin miscompares++; $display("FAIL rnd_phase[%0d]: got %h want %h", i, phase, m_acc[23:16]); end
      vectors++; if (sample_out !== e_sout) begin miscompares++; $display("FAIL rnd_sample[%0d]: got %h want %h", i, sample_out, e_sout); end
      vectors++; if (sample_valid !== e_svalid) begin miscompares++; $display("FAIL rnd_svalid[%0d]: got %b want %b", i, sample_valid, e_svalid); end
      vectors++; if (busy !== m_run) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_run); end
      vectors++; if (done !== m_fin) begin miscompares++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done, m_fin); end
      vectors++; if (cfg_bus.cfg_ready !== (!m_run && !m_fin)) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, cfg_bus.cfg_ready, !m_run && !m_fin); end
      vectors++; if (wave_sel !== sh_wave) begin miscompares++; $display("FAIL rnd_wave[%0d]: got %0d want %0d", i, wave_sel, sh_wave); end
    end
  endtask

  initial begin
    rst = 1; tick = 0; start = 0; stop = 0; cfg_bus.cfg_valid = 0;
    test_reset();
    test_cont();
    test_burst(2, 32);
    test_burst(0, 16);
    test_sweep(24'h300000, 30);
    test_sweep(24'h250000, 31);
    test_stop();
    test_tick_gate();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
